mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single memory port between instruction fetch (sf stage) and the data access (s2 mem stage).
// - Data has priority over fetch. data_busy feeds the pipeline's mem-in-use stall, which holds the PC.
// - Each transaction runs req/ack on the memory side and completes with a one-cycle done pulse to its requester.
// PARAMETERS
// - ADDR_W        30  word address width (byte address = {addr, 2'b0})
// - DATA_W        32  data word width
// - STARVE_LIMIT  4   consecutive data grants before a pending fetch is forced (only with FETCH_STARVE_GUARD_EN)
// PORTS
// - clk          in   1          clock; all state on posedge
// - rst_n        in   1          asynchronous, active-low reset
// - clk_enable   in   1          global pipeline enable; state and sampling advance only when high
// - fetch_req    in   1          fetch read request; held until fetch_done
// - fetch_addr   in   ADDR_W     fetch word address
// - fetch_done   out  1          1-cycle pulse: fetch_rdata valid
// - fetch_rdata  out  DATA_W     fetched instruction word
// - data_req     in   1          load/store request; held until data_done
// - data_we      in   1          1 = store, 0 = load
// - data_addr    in   ADDR_W     data word address
// - data_wdata   in   DATA_W     store data
// - data_be      in   DATA_W/8   store byte enables
// - data_done    out  1          1-cycle pulse: load data valid / store committed
// - data_rdata   out  DATA_W     load data
// - data_busy    out  1          comb: data_req & state!=RESP, or state==DATA
// - mem_req      out  1          memory request; held until mem_ack
// - mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted request
// - mem_ack      in   1          memory completion; mem_rdata is valid in the same cycle
// - mem_rdata    in   DATA_W     memory read data
// BEHAVIOUR
// - States: IDLE, FETCH, DATA, RESP.
//   - IDLE:  if data_req -> DATA; else if fetch_req -> FETCH; else stay.
//   - FETCH/DATA:  stay until mem_ack -> RESP.
//   - RESP:  -> IDLE unconditionally.
// - On grant (IDLE->FETCH/DATA edge): mem_req<=1; mem_addr/we/wdata/be latched. Fetch grants force mem_we=0, mem_be=0.
// - mem_* outputs stay stable while mem_req=1. On the mem_ack edge: mem_req<=0.
// - On the mem_ack edge, mem_rdata is latched into fetch_rdata or data_rdata for the owner. Store: data_rdata is left unchanged.
// - RESP: the owner's done=1 for exactly one cycle. Requests are not sampled in RESP.
//   - The requester drops or changes req on the edge ending RESP, so no duplicate grant is possible.
// - Latency: req seen in IDLE at cycle N -> mem_req high from N+1.
//   - mem_ack at cycle M>=N+1 -> done in M+1 -> IDLE at M+2.
//   - Minimum 3 cycles per transaction.
// - mem_ack in IDLE or RESP is ignored, with no state change.
// - A request withdrawn mid-transaction is still completed, and done still pulses.
// - clk_enable=0 freezes state, outputs and registers; mem_ack is not sampled. The memory must hold ack until sampled.
// - done pulses last one enabled cycle.
// - Simultaneous fetch_req and data_req in IDLE: data wins; fetch waits (fetch_done stays 0).
// - Reset (async, any state, including mid-transaction): the transaction is aborted.
//   - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
//   - fetch_done=0, data_done=0, fetch_rdata=0, data_rdata=0, starvation counter=0.
// CONFIGURATION
// - FETCH_STARVE_GUARD_EN defined:
//   - A counter increments on each data grant made while fetch_req=1, and clears on any fetch grant.
//   - When the counter reaches STARVE_LIMIT and both requests are pending in IDLE, fetch is granted.
// - FETCH_STARVE_GUARD_EN undefined: strict data priority; no counter logic is instantiated.
// TESTING
// - Reset mid-DATA with mem_req=1:
//   -> mem_req=0 immediately (async); after release state=IDLE, no done pulse.
// - Single fetch: fetch_req=1, addr=0x10 at N; mem_ack at N+3 with rdata=0x00500093
//   -> mem_req high N+1..N+3, mem_addr=0x10, mem_we=0; fetch_done=1 only at N+4 with fetch_rdata=0x00500093.
// - Collision: fetch_req and data_req (store, addr=0x40, wdata=0xDEADBEEF, be=4'b0011) both high at N
//   -> data granted first (mem_we=1, be=0011), data_done then fetch served; data_busy=1 until DATA exits.
// - Ack stall and enable: mem_ack withheld 10 cycles; clk_enable=0 for 3 cycles mid-wait
//   -> mem_* stable throughout, no done pulse, state holds; completes normally once ack is sampled enabled.
// - Stray mem_ack=1 in IDLE and in RESP
//   -> no state change, no extra done, rdata registers unchanged.
// - Guard (with FETCH_STARVE_GUARD_EN, STARVE_LIMIT=4): data_req held for back-to-back loads, fetch_req=1
//   -> the 5th grant goes to fetch. Without the macro, fetch is never granted while data_req=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data (data first; FETCH_STARVE_GUARD_EN adds a fetch anti-starvation guard).
// Latency: grant -> mem_req next cycle, done one cycle after sampled mem_ack; requests hold until done, mem_req holds until mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_enable,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_done,
  output logic [DATA_W-1:0]   fetch_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_be,
  output logic                data_done,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
  } mem_cmd_t;

  state_t   state;
  mem_cmd_t cmd_q;
  mem_cmd_t data_cmd;
  mem_cmd_t fetch_cmd;
  logic     fetch_forced;
  logic     grant_data;
  logic     grant_fetch;

  assign data_cmd  = '{we: data_we, addr: data_addr, wdata: data_wdata, be: data_be};
  assign fetch_cmd = '{we: 1'b0, addr: fetch_addr, wdata: '0, be: '0};

`ifdef FETCH_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign fetch_forced = fetch_req & data_req & (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Saturates at the limit so a long data burst cannot wrap it back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (clk_enable && state == IDLE) begin
      if (grant_fetch) begin
        starve_cnt <= '0;
      end else if (grant_data && fetch_req && starve_cnt < CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  assign grant_data  = data_req & ~fetch_forced;
  assign grant_fetch = fetch_req & ~grant_data;

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;

  // Held high through the whole data transaction so the pipeline keeps its PC.
  assign data_busy = (data_req & (state != RESP)) | (state == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      cmd_q       <= '0;
      fetch_done  <= 1'b0;
      data_done   <= 1'b0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state   <= DATA;
            mem_req <= 1'b1;
            cmd_q   <= data_cmd;
          end else if (grant_fetch) begin
            state   <= FETCH;
            mem_req <= 1'b1;
            cmd_q   <= fetch_cmd;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state       <= RESP;
            mem_req     <= 1'b0;
            fetch_rdata <= mem_rdata;
            fetch_done  <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            data_done <= 1'b1;
            if (!cmd_q.we) begin
              data_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          state      <= IDLE;
          fetch_done <= 1'b0;
          data_done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, randomized run against a transaction model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 30;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clk_enable;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_done;
  logic [DATA_W-1:0] fetch_rdata;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_be;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;
  logic              data_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_done(data_done), .data_rdata(data_rdata), .data_busy(data_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_enable = 1'b1;
    fetch_req  = 1'b0; fetch_addr = '0;
    data_req   = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    mem_ack    = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        freq; logic [29:0] fa;
    logic        dreq; logic dwe; logic [29:0] da; logic [31:0] dwd; logic [3:0] dbe;
    logic        ack;  logic [31:0] rd;
    logic        xreq; logic [29:0] xaddr; logic xwe; logic [3:0] xbe;
    logic        xfd;  logic xdd; logic xbusy; logic [31:0] xfrd; logic [31:0] xdrd;
  } vec_t;

  vec_t tbl[15];

  // Transaction-level model state for the randomized run.
  int          phase;          // 0 port free, 1 transaction on the bus, 2 completion reported
  bit          own_d;
  logic [29:0] e_addr;
  logic        e_we;
  logic [31:0] e_wd;
  logic [3:0]  e_be;
  logic [31:0] exp_frd, exp_drd;
  int          cnt;
  int          ack_cnt;
  logic [31:0] mem_m[16];
  bit          f_act, d_act, new_txn;
  bit          grants[$];
  bit          prev_req;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset values
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset mem_be", 32'(mem_be), 0);
    chk("reset fetch_done", 32'(fetch_done), 0);
    chk("reset data_done", 32'(data_done), 0);
    chk("reset fetch_rdata", fetch_rdata, 0);
    chk("reset data_rdata", data_rdata, 0);
    rst_n = 1'b1;

    // ---- vector table: single fetch, collision, stray acks, load
    tbl[0]  = '{1,'h10, 0,0,0,0,0, 0,0,             1,'h10,0,0, 0,0,0, 32'h0,        32'h0};
    tbl[1]  = '{1,'h10, 0,0,0,0,0, 0,0,             1,'h10,0,0, 0,0,0, 32'h0,        32'h0};
    tbl[2]  = '{1,'h10, 0,0,0,0,0, 0,0,             1,'h10,0,0, 0,0,0, 32'h0,        32'h0};
    tbl[3]  = '{1,'h10, 0,0,0,0,0, 1,32'h00500093,  0,'h10,0,0, 1,0,0, 32'h00500093, 32'h0};
    tbl[4]  = '{0,0,    0,0,0,0,0, 0,0,             0,'h10,0,0, 0,0,0, 32'h00500093, 32'h0};
    tbl[5]  = '{1,'h20, 1,1,'h40,32'hDEADBEEF,4'b0011, 0,0,            1,'h40,1,4'b0011, 0,0,1, 32'h00500093, 32'h0};
    tbl[6]  = '{1,'h20, 1,1,'h40,32'hDEADBEEF,4'b0011, 1,32'h12345678, 0,'h40,1,4'b0011, 0,1,0, 32'h00500093, 32'h0};
    tbl[7]  = '{1,'h20, 0,0,0,0,0, 0,0,             0,'h40,1,3, 0,0,0, 32'h00500093, 32'h0};
    tbl[8]  = '{1,'h20, 0,0,0,0,0, 0,0,             1,'h20,0,0, 0,0,0, 32'h00500093, 32'h0};
    tbl[9]  = '{1,'h20, 0,0,0,0,0, 1,32'hCAFEF00D,  0,'h20,0,0, 1,0,0, 32'hCAFEF00D, 32'h0};
    tbl[10] = '{0,0,    0,0,0,0,0, 1,32'h11111111,  0,'h20,0,0, 0,0,0, 32'hCAFEF00D, 32'h0};
    tbl[11] = '{0,0,    0,0,0,0,0, 1,32'h22222222,  0,'h20,0,0, 0,0,0, 32'hCAFEF00D, 32'h0};
    tbl[12] = '{0,0,    1,0,'h7,0,0, 0,0,           1,'h7,0,0,  0,0,1, 32'hCAFEF00D, 32'h0};
    tbl[13] = '{0,0,    1,0,'h7,0,0, 1,32'hA5A5A5A5, 0,'h7,0,0, 0,1,0, 32'hCAFEF00D, 32'hA5A5A5A5};
    tbl[14] = '{0,0,    0,0,0,0,0, 0,0,             0,'h7,0,0,  0,0,0, 32'hCAFEF00D, 32'hA5A5A5A5};

    for (int i = 0; i < 15; i++) begin
      fetch_req = tbl[i].freq; fetch_addr = tbl[i].fa;
      data_req = tbl[i].dreq; data_we = tbl[i].dwe; data_addr = tbl[i].da;
      data_wdata = tbl[i].dwd; data_be = tbl[i].dbe;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rd;
      step();
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tbl[i].xreq));
      if (tbl[i].xreq) begin
        chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].xaddr));
        chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].xwe));
        chk($sformatf("row%0d mem_be", i), 32'(mem_be), 32'(tbl[i].xbe));
      end
      chk($sformatf("row%0d fetch_done", i), 32'(fetch_done), 32'(tbl[i].xfd));
      chk($sformatf("row%0d data_done", i), 32'(data_done), 32'(tbl[i].xdd));
      chk($sformatf("row%0d data_busy", i), 32'(data_busy), 32'(tbl[i].xbusy));
      chk($sformatf("row%0d fetch_rdata", i), fetch_rdata, tbl[i].xfrd);
      chk($sformatf("row%0d data_rdata", i), data_rdata, tbl[i].xdrd);
    end

    // ---- asynchronous reset in the middle of a data transaction
    do_reset();
    data_req = 1'b1; data_we = 1'b0; data_addr = 30'h5;
    step();
    chk("midrst mem_req before", 32'(mem_req), 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst mem_req async", 32'(mem_req), 0);
    chk("midrst mem_addr async", 32'(mem_addr), 0);
    data_req = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("midrst c%0d data_done", c), 32'(data_done), 0);
      chk($sformatf("midrst c%0d mem_req", c), 32'(mem_req), 0);
    end
    fetch_req = 1'b1; fetch_addr = 30'h33;
    step();
    chk("midrst idle grant mem_req", 32'(mem_req), 1);
    chk("midrst idle grant mem_addr", 32'(mem_addr), 32'h33);
    mem_ack = 1'b1; mem_rdata = 32'h13;
    step();
    chk("midrst fetch_done", 32'(fetch_done), 1);
    fetch_req = 1'b0; mem_ack = 1'b0;
    step();

    // ---- ack withheld, pipeline enable dropped mid-wait
    do_reset();
    data_req = 1'b1; data_we = 1'b0; data_addr = 30'h7;
    step();
    chk("stall grant", 32'(mem_req), 1);
    for (int c = 0; c < 10; c++) begin
      clk_enable = !(c >= 4 && c <= 6);
      step();
      chk($sformatf("stall c%0d mem_req", c), 32'(mem_req), 1);
      chk($sformatf("stall c%0d mem_addr", c), 32'(mem_addr), 32'h7);
      chk($sformatf("stall c%0d data_done", c), 32'(data_done), 0);
    end
    clk_enable = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("stall dis-ack c%0d mem_req", c), 32'(mem_req), 1);
      chk($sformatf("stall dis-ack c%0d data_done", c), 32'(data_done), 0);
    end
    clk_enable = 1'b1;
    step();
    chk("stall done", 32'(data_done), 1);
    chk("stall data_rdata", data_rdata, 32'h0BADCAFE);
    chk("stall mem_req drop", 32'(mem_req), 0);
    data_req = 1'b0; mem_ack = 1'b0; clk_enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("stall frozen done c%0d", c), 32'(data_done), 1);
    end
    clk_enable = 1'b1;
    step();
    chk("stall done cleared", 32'(data_done), 0);

    // ---- back-to-back loads with a fetch waiting
    do_reset();
    fetch_req = 1'b1; fetch_addr = 30'h100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 30'h200;
    prev_req = 1'b0;
    grants.delete();
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      step();
      if (mem_req && !prev_req) grants.push_back(mem_addr == 30'h100);
      if (fetch_done) fetch_req = 1'b0;
      prev_req = mem_req;
      mem_ack  = mem_req;
    end
    chk("guard grant count reached", 32'(grants.size() >= 6), 1);
    if (grants.size() >= 6) begin
`ifdef FETCH_STARVE_GUARD_EN
      for (int g = 0; g < 4; g++) chk($sformatf("guard grant%0d is data", g), 32'(grants[g]), 0);
      chk("guard grant4 is fetch", 32'(grants[4]), 1);
`else
      for (int g = 0; g < 6; g++) chk($sformatf("strict grant%0d is data", g), 32'(grants[g]), 0);
`endif
    end
    data_req = 1'b0; fetch_req = 1'b0; mem_ack = 1'b0;
    repeat (4) step();

    // ---- randomized traffic against the transaction model
    do_reset();
    phase = 0; own_d = 0; cnt = 0; ack_cnt = 0;
    exp_frd = '0; exp_drd = '0; f_act = 0; d_act = 0;
    e_addr = '0; e_we = 0; e_wd = '0; e_be = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      new_txn = 0;
      if (clk_enable) begin
        case (phase)
          0: if (data_req || fetch_req) begin
               own_d = data_req;
`ifdef FETCH_STARVE_GUARD_EN
               if (data_req && fetch_req && cnt >= STARVE_LIMIT) own_d = 0;
               if (!own_d) cnt = 0;
               else if (fetch_req && cnt < STARVE_LIMIT) cnt++;
`endif
               if (own_d) begin
                 e_addr = data_addr; e_we = data_we; e_wd = data_wdata; e_be = data_be;
               end else begin
                 e_addr = fetch_addr; e_we = 0; e_wd = '0; e_be = '0;
               end
               phase = 1; new_txn = 1;
             end
          1: if (mem_ack) begin
               phase = 2;
               if (!own_d) exp_frd = mem_rdata;
               else if (!e_we) exp_drd = mem_rdata;
               else for (int b = 0; b < 4; b++) if (e_be[b]) mem_m[e_addr[3:0]][8*b +: 8] = e_wd[8*b +: 8];
             end
          default: phase = 0;
        endcase
      end
      step();
      chk($sformatf("rnd%0d mem_req", cyc), 32'(mem_req), 32'(phase == 1));
      if (phase == 1) begin
        chk($sformatf("rnd%0d mem_addr", cyc), 32'(mem_addr), 32'(e_addr));
        chk($sformatf("rnd%0d mem_we", cyc), 32'(mem_we), 32'(e_we));
        chk($sformatf("rnd%0d mem_be", cyc), 32'(mem_be), 32'(e_be));
        if (e_we) chk($sformatf("rnd%0d mem_wdata", cyc), mem_wdata, e_wd);
      end
      chk($sformatf("rnd%0d fetch_done", cyc), 32'(fetch_done), 32'(phase == 2 && !own_d));
      chk($sformatf("rnd%0d data_done", cyc), 32'(data_done), 32'(phase == 2 && own_d));
      chk($sformatf("rnd%0d data_busy", cyc), 32'(data_busy),
          32'((data_req && phase != 2) || (phase == 1 && own_d)));
      chk($sformatf("rnd%0d fetch_rdata", cyc), fetch_rdata, exp_frd);
      chk($sformatf("rnd%0d data_rdata", cyc), data_rdata, exp_drd);

      if (phase == 2) begin
        if (own_d) d_act = 0;
        else       f_act = 0;
      end
      if (phase != 2 && !f_act && $urandom_range(2) == 0) begin
        f_act = 1; fetch_addr = 30'($urandom_range(15));
      end
      if (phase != 2 && !d_act && $urandom_range(3) == 0) begin
        d_act = 1; data_we = 1'($urandom_range(1)); data_addr = 30'($urandom_range(15));
        data_wdata = $urandom; data_be = 4'($urandom_range(15));
      end
      fetch_req = f_act;
      data_req  = d_act;
      if (phase == 1) begin
        if (new_txn) begin
          mem_ack = 1'b0; ack_cnt = $urandom_range(3);
        end
        if (!mem_ack) begin
          if (ack_cnt == 0) begin
            mem_ack = 1'b1;
            mem_rdata = e_we ? $urandom : mem_m[e_addr[3:0]];
          end else begin
            ack_cnt--;
          end
        end
      end else begin
        mem_ack = ($urandom_range(4) == 0);
        mem_rdata = $urandom;
      end
      clk_enable = ($urandom_range(4) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
